epc_irq_stack: RTL and testbench

- Parametrised successor to the single-level exception PC latch; sits between the fetch PC mux and the interrupt sources of the MIPS core.
- Prioritises NUM_IRQ level-sensitive requests and redirects fetch to a per-source vector (VEC_BASE + id*VEC_STRIDE).
- Saves the interrupted PC, and the active priority, on a DEPTH-entry stack so higher-priority requests can nest. ERET pops the stack and redirects back.

---
 rtl/epc_pkg.sv | 40 ++++
 rtl/epc_lifo.sv | 61 ++++++
 rtl/epc_irq_stack.sv | 139 +++++++++++++
 tb/tb_epc_irq_stack.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/epc_pkg.sv
// Shared types and helpers for the nested interrupt / exception-PC stack.
// Vector addressing and request prioritisation live here so both sides agree.
package epc_pkg;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        VEC = 2'd1,
        RTN = 2'd2
    } state_t;

    localparam int MAX_IRQ = 32;
    localparam int MAX_ID_W = 5;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } prio_t;

    function automatic logic [63:0] vec_addr(
        input logic [63:0] id,
        input logic [63:0] base,
        input logic [63:0] stride
    );
        return base + id * stride;
    endfunction

    // Lowest set index wins.
    function automatic prio_t prio_enc(input logic [MAX_IRQ-1:0] req);
        prio_t r;
        r = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.id    = MAX_ID_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/epc_lifo.sv
// Register-file LIFO holding {return PC, previous active id} per nesting level.
// Only the occupancy pointer is reset; entry contents are don't-care.
module epc_lifo #(
    parameter int DEPTH = 4,
    parameter int W     = 34,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     top,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;

    logic [W-1:0]     mem_q [SLOTS];
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_d;
    logic [LVL_W-1:0] lvl_m1;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;

    assign lvl_m1 = lvl_q - LVL_W'(1);
    assign wr_ptr = PTR_W'(lvl_q);
    assign rd_ptr = PTR_W'(lvl_m1);
    assign full   = (lvl_q == LVL_W'(DEPTH));
    assign empty  = (lvl_q == '0);

    always_comb begin
        lvl_d = lvl_q;
        if (push && !full) begin
            lvl_d = lvl_q + LVL_W'(1);
        end else if (pop && !empty) begin
            lvl_d = lvl_m1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr] <= din;
        end
    end

    assign top   = mem_q[rd_ptr];
    assign level = lvl_q;

endmodule

// File: rtl/epc_irq_stack.sv
// Prioritised, nestable interrupt redirect with a saved-PC stack.
// Fetch sees a registered NEXT_PC; vector/return targets wait for TAKE.
module epc_irq_stack #(
    parameter int          NUM_IRQ    = 4,
    parameter int          DEPTH      = 4,
    parameter int          ADDR_W     = 32,
    parameter int unsigned VEC_BASE   = 108,
    parameter int unsigned VEC_STRIDE = 12,
    localparam int         ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int         LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic              IRQ_EN,
    input  logic [ADDR_W-1:0] PC,
    input  logic              RET,
    input  logic              TAKE,
    output logic [ADDR_W-1:0] NEXT_PC,
    output logic              REDIRECT,
    output logic [NUM_IRQ-1:0] ACK,
    output logic [ID_W-1:0]   ACTIVE_ID,
    output logic              IN_ISR,
    output logic [LVL_W-1:0]  LEVEL,
    output logic              ERR
);

    import epc_pkg::*;

    localparam int SW = ADDR_W + ID_W;

    state_t            state_q;
    logic [ADDR_W-1:0] next_pc_q;
    logic              redirect_q;
    logic [ID_W-1:0]   active_id_q;
    logic              err_q;

    prio_t             pe;
    logic              lvl_ok;
    logic              pri_ok;
    logic              eligible;
    logic              push;
    logic              pop;
    logic [SW-1:0]     top;
    logic [LVL_W-1:0]  level;
    logic [ADDR_W-1:0] vec_pc;
    logic [ADDR_W-1:0] ret_pc;
    logic [ID_W-1:0]   ret_id;

    assign pe     = prio_enc(MAX_IRQ'(IRQ));
    assign lvl_ok = (level < LVL_W'(DEPTH));
    assign pri_ok = (level == '0) || (pe.id < MAX_ID_W'(active_id_q));

    assign eligible = IRQ_EN && pe.valid && lvl_ok && pri_ok;
    assign push     = (state_q == RUN) && !RET && eligible;
    // The pop happens on the first RTN cycle, before REDIRECT rises.
    assign pop      = (state_q == RTN) && !redirect_q;

    assign vec_pc = ADDR_W'(vec_addr(64'(pe.id), 64'(VEC_BASE),
                                     64'(VEC_STRIDE)));
    assign {ret_pc, ret_id} = top;

    epc_lifo #(
        .DEPTH (DEPTH),
        .W     (SW),
        .LVL_W (LVL_W)
    ) u_lifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (pop),
        .din   ({PC, active_id_q}),
        .top   (top),
        .level (level)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RUN;
            next_pc_q   <= '0;
            redirect_q  <= 1'b0;
            active_id_q <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    next_pc_q <= PC;
                    if (RET) begin
                        if (level == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= RTN;
                        end
                    end else if (eligible) begin
                        next_pc_q   <= vec_pc;
                        redirect_q  <= 1'b1;
                        active_id_q <= ID_W'(pe.id);
                        state_q     <= VEC;
                    end
                end
                VEC: begin
                    if (TAKE) begin
                        redirect_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RTN: begin
                    if (!redirect_q) begin
                        next_pc_q   <= ret_pc;
                        active_id_q <= ret_id;
                        redirect_q  <= 1'b1;
                    end else if (TAKE) begin
                        redirect_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        ACK = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ACK[i] = (state_q == VEC) && TAKE &&
                     (active_id_q == ID_W'(i));
        end
    end

    assign NEXT_PC   = next_pc_q;
    assign REDIRECT  = redirect_q;
    assign ACTIVE_ID = active_id_q;
    assign IN_ISR    = (level != '0);
    assign LEVEL     = level;
    assign ERR       = err_q;

endmodule

// File: tb/tb_epc_irq_stack.sv
// Bench for epc_irq_stack: queue-based reference model checked every cycle,
// directed nesting/priority scenarios, then randomized traffic.
module tb_epc_irq_stack;

    localparam int NI   = 4;
    localparam int DP   = 2;
    localparam int AW   = 32;
    localparam int BASE = 108;
    localparam int STR  = 12;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [NI-1:0] IRQ = '0;
    logic          IRQ_EN = 1'b0;
    logic [AW-1:0] PC = '0;
    logic          RET = 1'b0;
    logic          TAKE = 1'b0;

    logic [AW-1:0] NEXT_PC;
    logic          REDIRECT;
    logic [NI-1:0] ACK;
    logic [1:0]    ACTIVE_ID;
    logic          IN_ISR;
    logic [1:0]    LEVEL;
    logic          ERR;

    epc_irq_stack #(
        .NUM_IRQ    (NI),
        .DEPTH      (DP),
        .ADDR_W     (AW),
        .VEC_BASE   (BASE),
        .VEC_STRIDE (STR)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IRQ       (IRQ),
        .IRQ_EN    (IRQ_EN),
        .PC        (PC),
        .RET       (RET),
        .TAKE      (TAKE),
        .NEXT_PC   (NEXT_PC),
        .REDIRECT  (REDIRECT),
        .ACK       (ACK),
        .ACTIVE_ID (ACTIVE_ID),
        .IN_ISR    (IN_ISR),
        .LEVEL     (LEVEL),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: saved contexts in a queue, a coarse phase marker.
    typedef struct {
        logic [AW-1:0] pc;
        int            id;
    } ent_t;

    ent_t          stk[$];
    ent_t          ent;
    int            m_phase = 0;
    logic [AW-1:0] m_pc = '0;
    bit            m_redir = 0;
    bit            m_err = 0;
    int            m_active = 0;
    int            m_cand;
    logic [NI-1:0] m_ack;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stk.delete();
            m_phase  = 0;
            m_pc     = '0;
            m_redir  = 0;
            m_err    = 0;
            m_active = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_pc = PC;
                    if (RET) begin
                        if (stk.size() == 0) m_err = 1;
                        else m_phase = 2;
                    end else begin
                        m_cand = -1;
                        for (int i = NI - 1; i >= 0; i--)
                            if (IRQ[i]) m_cand = i;
                        if (IRQ_EN && m_cand >= 0 && stk.size() < DP &&
                            (stk.size() == 0 || m_cand < m_active)) begin
                            stk.push_back('{PC, m_active});
                            m_active = m_cand;
                            m_pc     = AW'(BASE + m_cand * STR);
                            m_redir  = 1;
                            m_phase  = 1;
                        end
                    end
                end
                1: if (TAKE) begin
                    m_redir = 0;
                    m_phase = 0;
                end
                2: begin
                    ent      = stk.pop_back();
                    m_pc     = ent.pc;
                    m_active = ent.id;
                    m_redir  = 1;
                    m_phase  = 3;
                end
                default: if (TAKE) begin
                    m_redir = 0;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        m_ack = (m_phase == 1 && TAKE) ? NI'(1 << m_active) : '0;
        chk("next_pc", NEXT_PC, m_pc);
        chk("redirect", REDIRECT, m_redir);
        chk("ack", ACK, m_ack);
        chk("active_id", ACTIVE_ID, m_active);
        chk("in_isr", IN_ISR, stk.size() != 0);
        chk("level", LEVEL, stk.size());
        chk("err", ERR, m_err);
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_ret();
        RET = 1'b1;
        cyc();
        RET = 1'b0;
        cyc();
        TAKE = 1'b1;
        cyc();
        TAKE = 1'b0;
    endtask

    logic [NI-1:0] req;
    logic [NI-1:0] acks;

    initial begin
        repeat (3) cyc();
        chk("rst_next_pc", NEXT_PC, 0);
        chk("rst_redirect", REDIRECT, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_err", ERR, 0);
        RST_N = 1'b1;
        IRQ_EN = 1'b1;
        PC = 32'h100;
        cyc();

        // single interrupt and return
        PC = 32'h200;
        IRQ = 4'b0100;
        cyc();
        chk("t1_vec", NEXT_PC, 132);
        chk("t1_redir", REDIRECT, 1);
        chk("t1_level", LEVEL, 1);
        TAKE = 1'b1;
        IRQ = '0;
        #1 chk("t1_ack", ACK, 4'b0100);
        cyc();
        TAKE = 1'b0;
        #1 chk("t1_ack_off", ACK, 0);
        chk("t1_redir_off", REDIRECT, 0);
        PC = 32'h300;
        cyc();
        chk("t1_track", NEXT_PC, 32'h300);
        RET = 1'b1;
        cyc();
        RET = 1'b0;
        cyc();
        chk("t1_ret_pc", NEXT_PC, 32'h200);
        chk("t1_ret_redir", REDIRECT, 1);
        chk("t1_ret_level", LEVEL, 0);
        TAKE = 1'b1;
        cyc();
        TAKE = 1'b0;

        // nesting and priority
        PC = 32'h400;
        IRQ = 4'b0100;
        cyc();
        TAKE = 1'b1;
        IRQ = '0;
        cyc();
        TAKE = 1'b0;
        PC = 32'h500;
        IRQ = 4'b1000;
        cyc();
        chk("t2_low_pc", NEXT_PC, 32'h500);
        chk("t2_low_redir", REDIRECT, 0);
        IRQ = 4'b1001;
        cyc();
        chk("t2_vec0", NEXT_PC, 108);
        chk("t2_level2", LEVEL, 2);
        TAKE = 1'b1;
        IRQ = 4'b1000;
        cyc();
        TAKE = 1'b0;
        PC = 32'h600;
        RET = 1'b1;
        cyc();
        RET = 1'b0;
        cyc();
        chk("t2_ret1_pc", NEXT_PC, 32'h500);
        chk("t2_ret1_id", ACTIVE_ID, 2);
        chk("t2_ret1_lvl", LEVEL, 1);
        TAKE = 1'b1;
        cyc();
        TAKE = 1'b0;
        IRQ = '0;
        RET = 1'b1;
        cyc();
        RET = 1'b0;
        cyc();
        chk("t2_ret2_pc", NEXT_PC, 32'h400);
        chk("t2_ret2_id", ACTIVE_ID, 0);
        chk("t2_ret2_lvl", LEVEL, 0);
        TAKE = 1'b1;
        cyc();
        TAKE = 1'b0;

        // stack full
        PC = 32'h700;
        IRQ = 4'b0100;
        cyc();
        TAKE = 1'b1;
        IRQ = '0;
        cyc();
        TAKE = 1'b0;
        PC = 32'h800;
        IRQ = 4'b0010;
        cyc();
        chk("t3_vec1", NEXT_PC, 120);
        chk("t3_lvl2", LEVEL, 2);
        TAKE = 1'b1;
        IRQ = '0;
        cyc();
        TAKE = 1'b0;
        PC = 32'h900;
        IRQ = 4'b0001;
        repeat (3) begin
            cyc();
            chk("t3_full_redir", REDIRECT, 0);
            chk("t3_full_pc", NEXT_PC, 32'h900);
        end
        RET = 1'b1;
        cyc();
        RET = 1'b0;
        cyc();
        chk("t3_ret_pc", NEXT_PC, 32'h800);
        chk("t3_ret_lvl", LEVEL, 1);
        TAKE = 1'b1;
        cyc();
        TAKE = 1'b0;
        cyc();
        chk("t3_vec0", NEXT_PC, 108);
        chk("t3_vec0_lvl", LEVEL, 2);
        TAKE = 1'b1;
        IRQ = '0;
        cyc();
        TAKE = 1'b0;
        do_ret();
        do_ret();
        chk("t3_unwound", LEVEL, 0);

        // RET and IRQ in the same cycle
        PC = 32'hA00;
        IRQ = 4'b1000;
        cyc();
        chk("t4_vec3", NEXT_PC, 144);
        TAKE = 1'b1;
        IRQ = '0;
        cyc();
        TAKE = 1'b0;
        PC = 32'hB00;
        RET = 1'b1;
        IRQ = 4'b0010;
        cyc();
        RET = 1'b0;
        chk("t4_rtn_redir", REDIRECT, 0);
        chk("t4_rtn_pc", NEXT_PC, 32'hB00);
        cyc();
        chk("t4_ret_pc", NEXT_PC, 32'hA00);
        chk("t4_ret_redir", REDIRECT, 1);
        TAKE = 1'b1;
        cyc();
        TAKE = 1'b0;
        cyc();
        chk("t4_vec1", NEXT_PC, 120);
        TAKE = 1'b1;
        IRQ = '0;
        cyc();
        TAKE = 1'b0;
        do_ret();

        // RET with empty stack
        RET = 1'b1;
        cyc();
        RET = 1'b0;
        chk("t5_err", ERR, 1);
        chk("t5_redir", REDIRECT, 0);
        chk("t5_pc", NEXT_PC, 32'hB00);
        cyc();
        chk("t5_err_sticky", ERR, 1);

        // TAKE withheld in VEC
        PC = 32'hC00;
        IRQ = 4'b0100;
        cyc();
        repeat (5) begin
            cyc();
            chk("t5_stall_pc", NEXT_PC, 132);
            chk("t5_stall_redir", REDIRECT, 1);
            chk("t5_stall_ack", ACK, 0);
        end

        // async reset while a vector is pending
        #2 RST_N = 1'b0;
        #1 TAKE = 1'b1;
        #0 chk("t6_rst_pc", NEXT_PC, 0);
        chk("t6_rst_redir", REDIRECT, 0);
        chk("t6_rst_ack", ACK, 0);
        chk("t6_rst_lvl", LEVEL, 0);
        chk("t6_rst_err", ERR, 0);
        chk("t6_rst_isr", IN_ISR, 0);
        cyc();
        chk("t6_rst_ack2", ACK, 0);
        IRQ = '0;
        TAKE = 1'b0;
        RST_N = 1'b1;
        cyc();

        // randomized traffic; sources hold requests until acknowledged
        req = '0;
        acks = '0;
        repeat (3000) begin
            req &= ~acks;
            if ($urandom_range(0, 3) == 0)
                req |= NI'(1 << $urandom_range(0, NI - 1));
            IRQ = req;
            IRQ_EN = ($urandom_range(0, 7) != 0);
            PC = $urandom & 32'hFFFF_FFFC;
            RET = ($urandom_range(0, 9) == 0);
            TAKE = $urandom_range(0, 1);
            #3 acks = ACK;
            @(posedge CLK);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
